t06_lcd_cmd_decoder: RTL

//  Receiving end of the 8080-style LCD write bus (D[7:0], dcx, wrx, csx) driven by the t06 command LUTs.

---
 rtl/t06_lcd_pkg.sv | 33 +++
 rtl/t06_edge_sync.sv | 34 +++
 rtl/t06_lcd_cmd_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/t06_lcd_pkg.sv
// Shared definitions for the t06 LCD command path: opcodes, decoder FSM states
// and RGB565 colour constants.
package t06_lcd_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_PIX_HI,
    ST_PIX_LO
  } lcd_state_t;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  // Index of the final parameter byte for a parameterised command.
  function automatic logic [1:0] param_last(input logic [7:0] op);
    return (op == OP_CASET || op == OP_PASET) ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/t06_edge_sync.sv
// Multi-flop synchronizer with registered rising-edge pulse, gated by an
// active-low qualifier that travels through an identical synchronizer.
module t06_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LVL    = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic sig,
  input  logic gate_n,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sig_sync;
  logic [SYNC_STAGES-1:0] gate_sync;
  logic                   sig_prev;

  // Reset to the idle level so an idle-high line never produces a false edge
  // on reset release, and anything in flight is discarded.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sig_sync  <= {SYNC_STAGES{IDLE_LVL}};
      gate_sync <= '1;
      sig_prev  <= IDLE_LVL;
      rise      <= 1'b0;
    end else begin
      sig_sync  <= {sig_sync[SYNC_STAGES-2:0], sig};
      gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate_n};
      sig_prev  <= sig_sync[SYNC_STAGES-1];
      rise      <= sig_sync[SYNC_STAGES-1] & ~sig_prev & ~gate_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/t06_lcd_cmd_decoder.sv
// Panel-side decoder for the 8080-style LCD write bus: tracks window, sleep and
// display state and emits one pixel strobe per completed RAMWR byte pair.
module t06_lcd_cmd_decoder
  import t06_lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_COL     = 239,
  parameter int unsigned MAX_PAGE    = 319
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        csx,
  input  logic        wrx,
  input  logic        dcx,
  input  logic [7:0]  d,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic [15:0] pix_color,
  output logic        sleeping,
  output logic        disp_on,
  output logic [15:0] win_sc,
  output logic [15:0] win_ec,
  output logic [15:0] win_sp,
  output logic [15:0] win_ep,
  output logic        err_pulse
);

  localparam logic [15:0] EC_RST = 16'(MAX_COL);
  localparam logic [15:0] EP_RST = 16'(MAX_PAGE);

  logic        wr_rise;
  logic [7:0]  d_q;
  logic        dcx_q;
  logic        rx_valid;
  logic        rx_dcx;
  logic [7:0]  rx_d;

  lcd_state_t  state_q, state_n;
  logic [1:0]  pcnt_q, pcnt_n;
  logic [7:0]  cmd_q, cmd_n;
  logic [23:0] par_q, par_n;
  logic [7:0]  hi_q, hi_n;
  logic [15:0] col_q, col_n;
  logic [15:0] page_q, page_n;
  logic [15:0] win_sc_n, win_ec_n, win_sp_n, win_ep_n;
  logic [15:0] pix_x_n, pix_y_n, pix_color_n;
  logic        pix_valid_n, sleeping_n, disp_on_n, err_n;
  logic [15:0] p_start, p_end;

  t06_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LVL    (1'b1)
  ) u_wrx_sync (
    .clk    (clk),
    .nrst   (nrst),
    .sig    (wrx),
    .gate_n (csx),
    .rise   (wr_rise)
  );

  // d/dcx are sampled every cycle so the byte taken is the one present on the
  // cycle the edge was detected, while the pulse itself arrives one cycle later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_q      <= '0;
      dcx_q    <= 1'b0;
      rx_valid <= 1'b0;
      rx_dcx   <= 1'b0;
      rx_d     <= '0;
    end else begin
      d_q      <= d;
      dcx_q    <= dcx;
      rx_valid <= wr_rise;
      if (wr_rise) begin
        rx_dcx <= dcx_q;
        rx_d   <= d_q;
      end
    end
  end

  assign p_start = par_q[23:8];
  assign p_end   = {par_q[7:0], rx_d};

  always_comb begin
    state_n     = state_q;
    pcnt_n      = pcnt_q;
    cmd_n       = cmd_q;
    par_n       = par_q;
    hi_n        = hi_q;
    col_n       = col_q;
    page_n      = page_q;
    win_sc_n    = win_sc;
    win_ec_n    = win_ec;
    win_sp_n    = win_sp;
    win_ep_n    = win_ep;
    pix_x_n     = pix_x;
    pix_y_n     = pix_y;
    pix_color_n = pix_color;
    sleeping_n  = sleeping;
    disp_on_n   = disp_on;
    pix_valid_n = 1'b0;
    err_n       = 1'b0;

    if (rx_valid) begin
      if (!rx_dcx) begin
        state_n = ST_IDLE;
        pcnt_n  = '0;
        cmd_n   = rx_d;
        case (rx_d)
          OP_SWRESET: begin
            sleeping_n  = 1'b1;
            disp_on_n   = 1'b0;
            win_sc_n    = '0;
            win_ec_n    = EC_RST;
            win_sp_n    = '0;
            win_ep_n    = EP_RST;
            pix_x_n     = '0;
            pix_y_n     = '0;
            pix_color_n = '0;
            col_n       = '0;
            page_n      = '0;
            par_n       = '0;
            hi_n        = '0;
          end
          OP_SLPOUT:  sleeping_n = 1'b0;
          OP_DISPON:  disp_on_n  = 1'b1;
          OP_DISPOFF: disp_on_n  = 1'b0;
          OP_CASET, OP_PASET, OP_MADCTL, OP_COLMOD: state_n = ST_PARAM;
          OP_RAMWR: begin
            state_n = ST_PIX_HI;
            col_n   = win_sc;
            page_n  = win_sp;
          end
          default: err_n = 1'b1;
        endcase
      end else begin
        case (state_q)
          ST_PARAM: begin
            par_n  = {par_q[15:0], rx_d};
            pcnt_n = pcnt_q + 2'd1;
            if (pcnt_q == param_last(cmd_q)) begin
              state_n = ST_IDLE;
              pcnt_n  = '0;
              if (cmd_q == OP_CASET || cmd_q == OP_PASET) begin
                if (p_start <= p_end) begin
                  if (cmd_q == OP_CASET) begin
                    win_sc_n = p_start;
                    win_ec_n = p_end;
                  end else begin
                    win_sp_n = p_start;
                    win_ep_n = p_end;
                  end
                end else begin
                  err_n = 1'b1;
                end
              end
            end
          end
          ST_PIX_HI: begin
            hi_n    = rx_d;
            state_n = ST_PIX_LO;
          end
          ST_PIX_LO: begin
            pix_valid_n = 1'b1;
            pix_color_n = {hi_q, rx_d};
            pix_x_n     = col_q;
            pix_y_n     = page_q;
            state_n     = ST_PIX_HI;
            if (col_q == win_ec) begin
              col_n  = win_sc;
              page_n = (page_q == win_ep) ? win_sp : page_q + 16'd1;
            end else begin
              col_n  = col_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      cmd_q     <= '0;
      par_q     <= '0;
      hi_q      <= '0;
      col_q     <= '0;
      page_q    <= '0;
      win_sc    <= '0;
      win_ec    <= EC_RST;
      win_sp    <= '0;
      win_ep    <= EP_RST;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      sleeping  <= 1'b1;
      disp_on   <= 1'b0;
      pix_valid <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_n;
      pcnt_q    <= pcnt_n;
      cmd_q     <= cmd_n;
      par_q     <= par_n;
      hi_q      <= hi_n;
      col_q     <= col_n;
      page_q    <= page_n;
      win_sc    <= win_sc_n;
      win_ec    <= win_ec_n;
      win_sp    <= win_sp_n;
      win_ep    <= win_ep_n;
      pix_x     <= pix_x_n;
      pix_y     <= pix_y_n;
      pix_color <= pix_color_n;
      sleeping  <= sleeping_n;
      disp_on   <= disp_on_n;
      pix_valid <= pix_valid_n;
      err_pulse <= err_n;
    end
  end

endmodule
